// File: rtl/dense_layer_engine.sv
// Fully-connected layer engine: buffers one input vector, streams weights/bias from
// a synchronous RAM per output node, accumulates in fixed point and applies an activation.
module dense_layer_engine #(
  parameter int DATA_WIDTH            = 32,
  parameter int FRAC_BITS             = 16,
  parameter int NUMBER_OF_INPUT_NODE  = 2,
  parameter int NUMBER_OF_OUTPUT_NODE = 32,
  parameter int WEIGHT_ADDR_WIDTH     = 8,
  parameter int LEAKY_SHIFT           = 3,
  localparam int NODE_W = (NUMBER_OF_OUTPUT_NODE > 1) ? $clog2(NUMBER_OF_OUTPUT_NODE) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_ready,
  input  logic [1:0]                   i_act_mode,
  output logic [WEIGHT_ADDR_WIDTH-1:0] o_weight_addr,
  input  logic [DATA_WIDTH-1:0]        i_weight_data,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [NODE_W-1:0]            o_node_index,
  input  logic                         i_out_ready,
  output logic                         o_done,
  output logic                         o_sat
);

  localparam int N_IN   = NUMBER_OF_INPUT_NODE;
  localparam int N_OUT  = NUMBER_OF_OUTPUT_NODE;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(N_IN + 1);
  localparam int IN_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CYC_W  = $clog2(N_IN + 2);
  localparam int WA     = WEIGHT_ADDR_WIDTH;

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_ACT, S_OUT} state_e;

  state_e                        state_q, state_d;
  logic                          ready_q, ready_d;
  logic [IN_W-1:0]               in_cnt_q, in_cnt_d;
  logic signed [DATA_WIDTH-1:0]  x_q [N_IN];
  logic signed [DATA_WIDTH-1:0]  x_d [N_IN];
  logic [1:0]                    mode_q, mode_d;
  logic                          sat_q, sat_d;
  logic [NODE_W-1:0]             node_q, node_d;
  logic [NODE_W-1:0]             idx_q, idx_d;
  logic [CYC_W-1:0]              cyc_q, cyc_d;
  logic [WA-1:0]                 addr_q, addr_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic                          valid_q, valid_d;
  logic [DATA_WIDTH-1:0]         data_q, data_d;
  logic                          done_q, done_d;

  logic signed [DATA_WIDTH-1:0]  x_sel;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       prod_ext, bias_ext, acc_shr;
  logic [ACC_W-DATA_WIDTH:0]     hi;
  logic                          ovf;
  logic signed [DATA_WIDTH-1:0]  clamped, act_val;
  logic                          last_in, last_node, last_cyc;

  // Weight arriving in MAC cycle c pairs with x[c-1] (RAM read latency of one).
  always_comb begin
    x_sel = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (cyc_q == CYC_W'(k + 1)) x_sel = x_q[k];
    end
  end

  always_comb begin
    prod     = PROD_W'($signed(i_weight_data)) * PROD_W'(x_sel);
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'($signed(i_weight_data)) <<< FRAC_BITS;
    acc_shr  = acc_q >>> FRAC_BITS;
    // Result fits only if every bit above the target sign bit equals the sign.
    hi       = acc_shr[ACC_W-1:DATA_WIDTH-1];
    ovf      = !((&hi) || !(|hi));
    if (ovf) clamped = acc_shr[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else     clamped = acc_shr[DATA_WIDTH-1:0];
    case (mode_q)
      2'd1:    act_val = clamped[DATA_WIDTH-1] ? '0 : clamped;
      2'd2:    act_val = clamped[DATA_WIDTH-1] ? (clamped >>> LEAKY_SHIFT) : clamped;
      default: act_val = clamped;
    endcase
  end

  assign last_in   = (in_cnt_q == IN_W'(N_IN - 1));
  assign last_node = (node_q == NODE_W'(N_OUT - 1));
  assign last_cyc  = (cyc_q == CYC_W'(N_IN + 1));

  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    in_cnt_d = in_cnt_q;
    x_d      = x_q;
    mode_d   = mode_q;
    sat_d    = sat_q;
    node_d   = node_q;
    idx_d    = idx_q;
    cyc_d    = cyc_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    valid_d  = valid_q;
    data_d   = data_q;
    done_d   = 1'b0;
    case (state_q)
      S_LOAD: begin
        ready_d = 1'b1;
        if (i_valid && ready_q) begin
          for (int unsigned k = 0; k < N_IN; k++) begin
            if (in_cnt_q == IN_W'(k)) x_d[k] = i_data;
          end
          if (in_cnt_q == '0) begin
            mode_d = i_act_mode;
            sat_d  = 1'b0;
          end
          if (last_in) begin
            in_cnt_d = '0;
            ready_d  = 1'b0;
            node_d   = '0;
            cyc_d    = '0;
            acc_d    = '0;
            addr_d   = '0;
            state_d  = S_MAC;
          end else begin
            in_cnt_d = in_cnt_q + IN_W'(1);
          end
        end
      end
      S_MAC: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q < CYC_W'(N_IN)) addr_d = addr_q + WA'(1);
        if (cyc_q != '0) acc_d = acc_q + (last_cyc ? bias_ext : prod_ext);
        if (last_cyc) state_d = S_ACT;
      end
      S_ACT: begin
        data_d  = act_val;
        valid_d = 1'b1;
        idx_d   = node_q;
        if (ovf) sat_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (i_out_ready) begin
          valid_d = 1'b0;
          if (last_node) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = S_LOAD;
          end else begin
            node_d  = node_q + NODE_W'(1);
            cyc_d   = '0;
            acc_d   = '0;
            addr_d  = addr_q + WA'(1);
            state_d = S_MAC;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      ready_q  <= 1'b0;
      in_cnt_q <= '0;
      x_q      <= '{default: '0};
      mode_q   <= '0;
      sat_q    <= 1'b0;
      node_q   <= '0;
      idx_q    <= '0;
      cyc_q    <= '0;
      addr_q   <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      in_cnt_q <= in_cnt_d;
      x_q      <= x_d;
      mode_q   <= mode_d;
      sat_q    <= sat_d;
      node_q   <= node_d;
      idx_q    <= idx_d;
      cyc_q    <= cyc_d;
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_weight_addr = addr_q;
  assign o_valid       = valid_q;
  assign o_data        = data_q;
  assign o_node_index  = idx_q;
  assign o_done        = done_q;
  assign o_sat         = sat_q;

endmodule

// File: doc/dense_layer_engine.md
Name: dense_layer_engine

Overview:
- Parametrised fully-connected layer engine; successor to the fixed-size hidden-layer feed-forward block of the DQN datapath.
- Accepts an input activation vector as a stream and holds it in an internal buffer. For each output node it streams the weights and bias from an external synchronous RAM and accumulates the dot product in signed fixed point.
- Applies a run-time-selectable activation (linear / ReLU / leaky ReLU) and emits one result per output node, with output backpressure.
- Sits between layer RAMs in both the policy and target networks; one instance per layer.

Parameters:
- DATA_WIDTH, 32, signed fixed-point word width for data, weights, bias and results.
- FRAC_BITS, 16, fractional bits (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
- NUMBER_OF_INPUT_NODE, 2, input vector length N_IN (≥1).
- NUMBER_OF_OUTPUT_NODE, 32, output vector length N_OUT (≥1).
- WEIGHT_ADDR_WIDTH, 8, weight RAM address width; must satisfy 2^W ≥ N_OUT*(N_IN+1).
- LEAKY_SHIFT, 3, leaky-ReLU negative slope = 2^-LEAKY_SHIFT.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  input element valid.
- i_data  input  DATA_WIDTH  input element, in order x[0]..x[N_IN-1].
- o_ready  output  1  engine can accept an input element.
- i_act_mode  input  2  0 linear, 1 ReLU, 2 leaky ReLU, 3 reserved (treated as linear).
- o_weight_addr  output  WEIGHT_ADDR_WIDTH  weight RAM read address.
- i_weight_data  input  DATA_WIDTH  RAM read data, valid one cycle after the address.
- o_valid  output  1  result valid.
- o_data  output  DATA_WIDTH  activated result.
- o_node_index  output  clog2(N_OUT) (min 1)  output node of o_data.
- i_out_ready  input  1  downstream accepts the result.
- o_done  output  1  one-cycle pulse after the last node is accepted.
- o_sat  output  1  sticky: a saturation occurred in the current vector.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous, active-low. While rst_n=0: state LOAD, all counters 0, o_ready=0, o_valid=0, o_data=0, o_node_index=0, o_weight_addr=0, o_done=0, o_sat=0. o_ready rises on the first clock edge after reset release.
- Weight RAM layout: the word at address j*(N_IN+1)+k is the weight for node j, input k (k<N_IN). The word at address j*(N_IN+1)+N_IN is the bias for node j.
- LOAD state:
  - o_ready=1; an element is accepted when i_valid & o_ready.
  - i_act_mode is sampled on acceptance of x[0] and held for the whole vector.
  - o_sat is cleared on acceptance of x[0].
  - On acceptance of x[N_IN-1]: o_ready drops the next cycle, node counter j=0, go to MAC.
- MAC state:
  - Lasts exactly N_IN+2 cycles per node.
  - Cycle c (0..N_IN) drives address j*(N_IN+1)+c.
  - Cycle c (1..N_IN) adds i_weight_data*x[c-1] (full 2*DATA_WIDTH product) to the accumulator.
  - Cycle N_IN+1 adds bias<<FRAC_BITS.
  - Accumulator width is 2*DATA_WIDTH+clog2(N_IN+1); it is cleared on entry to MAC.
- ACT state (1 cycle):
  - Arithmetic right shift of the accumulator by FRAC_BITS (floor).
  - Saturate to the signed DATA_WIDTH range; set o_sat on clamp.
  - Then activation:
    - ReLU: negative → 0.
    - Leaky ReLU: negative → value>>>LEAKY_SHIFT.
  - Register the result into o_data, set o_valid=1 and o_node_index=j.
- OUT state:
  - o_valid, o_data and o_node_index are held stable until i_out_ready=1.
  - On acceptance: o_valid=0 next cycle.
  - If j<N_OUT-1: j+1, go to MAC.
  - Else: pulse o_done for 1 cycle and return to LOAD.
- Latency: one node = N_IN+3 cycles from MAC entry to o_valid, plus any backpressure stall.
- Boundaries:
  - N_IN=1 is legal.
  - i_valid while o_ready=0 is ignored and no data is consumed.
  - i_out_ready is ignored outside OUT.
  - i_act_mode changes mid-vector have no effect.
  - o_done and o_ready re-asserting happen in the same cycle.
  - Reset mid-MAC or mid-OUT aborts the vector with no further o_valid; the buffer contents are don't-care.

Test Plan:
- Setup for all scenarios: N_IN=2, N_OUT=4, FRAC_BITS=16, LEAKY_SHIFT=3, RAM latency 1.
- Basic MAC:
  - Stimulus: x=[0x00010000,0x00020000]; node0 w=[0x00008000,0x00004000], bias 0x00002000; mode linear.
  - Required: o_data=0x00012000 (1.125), o_node_index=0, o_valid exactly 5 cycles after MAC entry.
- Activations:
  - Stimulus: same x; node1 w=[0xFFFF0000,0xFFFF0000], bias 0.
  - Required: linear → 0xFFFD0000; ReLU → 0x00000000; leaky → 0xFFFFA000.
- Saturation:
  - Stimulus: x=[0x75300000,0x75300000] (30000.0); w=[0x00010000,0x00010000], bias 0.
  - Required: o_data=0x7FFFFFFF, o_sat=1; o_sat=0 after the next vector's x[0] is accepted.
- Backpressure and sequencing:
  - Stimulus: hold i_out_ready=0 for 5 cycles on node2.
  - Required: o_data and o_node_index stable, o_valid high throughout.
  - Required: node indices come out 0,1,2,3; o_done pulses once after node3 is accepted; o_ready=1 in the same cycle.
- Input handshake:
  - Stimulus: drive i_valid during MAC.
  - Required: ignored, and o_weight_addr sequence 0,1,2,3,4,5,... unchanged.
- Reset mid-operation:
  - Stimulus: rst_n low during MAC of node1.
  - Required: o_valid=0 and o_sat=0 immediately; o_ready=1 one edge after release; a fresh vector produces correct results.
